// File: rtl/audio_pkg.sv
// Shared audio constants and elaboration-time parameter checks.
package audio_pkg;

    localparam int unsigned FMT_I2S = 0;
    localparam int unsigned FMT_LJ  = 1;

    // A sample must fit inside its slot.
    function automatic bit slot_fits(input int unsigned sample_w, input int unsigned slot_w);
        return (sample_w >= 1) && (slot_w >= sample_w);
    endfunction

    // The BCLK divider needs at least one CLK cycle per half-period.
    function automatic bit div_ok(input int unsigned clk_div);
        return clk_div >= 1;
    endfunction

    // Only the I2S and left-justified framings exist.
    function automatic bit fmt_ok(input int unsigned fmt);
        return (fmt == FMT_I2S) || (fmt == FMT_LJ);
    endfunction

endpackage

// File: rtl/i2s_clk_gen.sv
// BCLK generator: divides CLK by 2*CLK_DIV and flags the BCLK falling event.
module i2s_clk_gen
    import audio_pkg::*;
#(
    parameter int unsigned CLK_DIV = 4
) (
    input  logic CLK,
    input  logic RESET,
    output logic o_bclk,
    output logic o_fall_c
);

    localparam int unsigned DIV_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

    logic [DIV_W-1:0] r_div_cnt;
    logic             r_bclk;
    logic             w_tc;

    assign w_tc     = (r_div_cnt == DIV_W'(CLK_DIV - 1));
    assign o_fall_c = w_tc & r_bclk;
    assign o_bclk   = r_bclk;

    // Half-period counter; BCLK toggles at each terminal count.
    always_ff @(posedge CLK) begin
        if (RESET) begin
            r_div_cnt <= '0;
            r_bclk    <= 1'b0;
        end else if (w_tc) begin
            r_div_cnt <= '0;
            r_bclk    <= ~r_bclk;
        end else begin
            r_div_cnt <= r_div_cnt + DIV_W'(1);
        end
    end

endmodule

// File: rtl/i2s_tx_master.sv
// I2S / left-justified stereo DAC transmitter, BCLK/LRCLK master, with a one-frame sample buffer.
module i2s_tx_master
    import audio_pkg::*;
#(
    parameter int unsigned SAMPLE_WIDTH  = 16,
    parameter int unsigned SLOT_WIDTH    = 32,
    parameter int unsigned CLK_DIV       = 4,
    parameter int unsigned FORMAT        = FMT_I2S,
    parameter int unsigned MUTE_ON_UNDER = 1
) (
    input  logic                    CLK,
    input  logic                    RESET,
    input  logic                    s_valid,
    output logic                    s_ready,
    input  logic [SAMPLE_WIDTH-1:0] s_left,
    input  logic [SAMPLE_WIDTH-1:0] s_right,
    output logic                    BCLK,
    output logic                    LRCLK,
    output logic                    DACDAT,
    output logic                    frame_start,
    output logic                    underrun
);

    localparam int unsigned FRAME_BITS = 2 * SLOT_WIDTH;
    localparam int unsigned POS_W      = $clog2(FRAME_BITS);
    localparam int unsigned LAST_POS   = FRAME_BITS - 1;

    // Reject impossible configurations at elaboration.
    if (!slot_fits(SAMPLE_WIDTH, SLOT_WIDTH)) begin : g_err_slot
        $error("i2s_tx_master: SLOT_WIDTH must be >= SAMPLE_WIDTH");
    end
    if (!div_ok(CLK_DIV)) begin : g_err_div
        $error("i2s_tx_master: CLK_DIV must be >= 1");
    end
    if (!fmt_ok(FORMAT)) begin : g_err_fmt
        $error("i2s_tx_master: FORMAT must be FMT_I2S or FMT_LJ");
    end

    logic                    w_bclk;
    logic                    w_fall_c;
    logic                    w_load_c;
    logic                    w_accept_c;
    logic                    w_buf_full_nxt;
    logic [POS_W-1:0]        w_pos_next;
    logic [POS_W-1:0]        w_bit_idx;
    logic [FRAME_BITS-1:0]   w_stream;
    logic                    w_stream_bit;
    logic [SAMPLE_WIDTH-1:0] w_frame_left_nxt;
    logic [SAMPLE_WIDTH-1:0] w_frame_right_nxt;
    logic [SAMPLE_WIDTH-1:0] w_src_left;
    logic [SAMPLE_WIDTH-1:0] w_src_right;

    logic [SAMPLE_WIDTH-1:0] r_buf_left;
    logic [SAMPLE_WIDTH-1:0] r_buf_right;
    logic                    r_buf_full;
    logic                    r_s_ready;
    logic [SAMPLE_WIDTH-1:0] r_frame_left;
    logic [SAMPLE_WIDTH-1:0] r_frame_right;
    logic [POS_W-1:0]        r_pos;
    logic                    r_lrclk;
    logic                    r_dacdat;
    logic                    r_frame_start;
    logic                    r_underrun;

    i2s_clk_gen #(
        .CLK_DIV (CLK_DIV)
    ) u_clk_gen (
        .CLK      (CLK),
        .RESET    (RESET),
        .o_bclk   (w_bclk),
        .o_fall_c (w_fall_c)
    );

    assign w_pos_next = (r_pos == POS_W'(LAST_POS)) ? '0 : r_pos + POS_W'(1);
    assign w_load_c   = w_fall_c & (r_pos == POS_W'(LAST_POS));
    assign w_accept_c = s_valid & r_s_ready;

    // Buffer occupancy after this cycle: a load drains it, an accept fills it (never both).
    always_comb begin
        w_buf_full_nxt = r_buf_full;
        if (w_load_c && r_buf_full) begin
            w_buf_full_nxt = 1'b0;
        end else if (w_accept_c) begin
            w_buf_full_nxt = 1'b1;
        end
    end

    // Frame register contents after this cycle, including underrun mute/repeat.
    always_comb begin
        w_frame_left_nxt  = r_frame_left;
        w_frame_right_nxt = r_frame_right;
        if (w_load_c) begin
            if (r_buf_full) begin
                w_frame_left_nxt  = r_buf_left;
                w_frame_right_nxt = r_buf_right;
            end else if (MUTE_ON_UNDER != 0) begin
                w_frame_left_nxt  = '0;
                w_frame_right_nxt = '0;
            end
        end
    end

    // Bit mux: LJ shows the new position of the (possibly just loaded) frame; I2S lags one bit
    // and so still shows the outgoing frame's last bit at position 0.
    always_comb begin
        w_bit_idx   = '0;
        w_src_left  = r_frame_left;
        w_src_right = r_frame_right;
        if (FORMAT == FMT_LJ) begin
            w_bit_idx   = w_pos_next;
            w_src_left  = w_frame_left_nxt;
            w_src_right = w_frame_right_nxt;
        end else begin
            w_bit_idx = (w_pos_next == '0) ? POS_W'(LAST_POS) : w_pos_next - POS_W'(1);
        end
        w_stream = '0;
        for (int i = 0; i < int'(SAMPLE_WIDTH); i++) begin
            w_stream[i]                   = w_src_left[int'(SAMPLE_WIDTH) - 1 - i];
            w_stream[int'(SLOT_WIDTH) + i] = w_src_right[int'(SAMPLE_WIDTH) - 1 - i];
        end
    end

    assign w_stream_bit = w_stream[w_bit_idx];

    // Sample buffer and ready handshake.
    always_ff @(posedge CLK) begin
        if (RESET) begin
            r_buf_left  <= '0;
            r_buf_right <= '0;
            r_buf_full  <= 1'b0;
            r_s_ready   <= 1'b0;
        end else begin
            if (w_accept_c) begin
                r_buf_left  <= s_left;
                r_buf_right <= s_right;
            end
            r_buf_full <= w_buf_full_nxt;
            r_s_ready  <= ~w_buf_full_nxt;
        end
    end

    // Frame register, slot position, LRCLK/DACDAT and the load/underrun pulses.
    always_ff @(posedge CLK) begin
        if (RESET) begin
            r_frame_left  <= '0;
            r_frame_right <= '0;
            r_pos         <= POS_W'(LAST_POS);
            r_lrclk       <= 1'b0;
            r_dacdat      <= 1'b0;
            r_frame_start <= 1'b0;
            r_underrun    <= 1'b0;
        end else begin
            r_frame_left  <= w_frame_left_nxt;
            r_frame_right <= w_frame_right_nxt;
            r_frame_start <= w_load_c;
            r_underrun    <= w_load_c & ~r_buf_full;
            if (w_fall_c) begin
                r_pos    <= w_pos_next;
                r_lrclk  <= (w_pos_next >= POS_W'(SLOT_WIDTH));
                r_dacdat <= w_stream_bit;
            end
        end
    end

    assign s_ready     = r_s_ready;
    assign BCLK        = w_bclk;
    assign LRCLK       = r_lrclk;
    assign DACDAT      = r_dacdat;
    assign frame_start = r_frame_start;
    assign underrun    = r_underrun;

endmodule

// File: tb/tb_i2s_tx_master.sv
// Bench for i2s_tx_master: four configurations run side by side against a frame-level model.
module tb_i2s_tx_master;
    import audio_pkg::*;

    localparam int NCFG  = 4;
    localparam int LIMIT = 20000;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fails  = 0;

    task automatic check(input int cfg, input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fails++;
            $display("FAIL cfg%0d %s: got %h expected %h at %0t", cfg, name, act, exp, $time);
        end
    endtask

    // Configuration table: format, sample width, slot width, divider, mute, literal pair.
    function automatic int unsigned cfg_fmt(input int i);
        case (i) 0: return FMT_LJ; 1: return FMT_I2S; 2: return FMT_I2S; default: return FMT_LJ; endcase
    endfunction
    function automatic int unsigned cfg_sample(input int i);
        case (i) 2: return 24; default: return 16; endcase
    endfunction
    function automatic int unsigned cfg_slot(input int i);
        case (i) 0: return 16; 2: return 24; default: return 32; endcase
    endfunction
    function automatic int unsigned cfg_div(input int i);
        case (i) 1: return 4; 3: return 2; default: return 1; endcase
    endfunction
    function automatic int unsigned cfg_mute(input int i);
        case (i) 0: return 1; 1: return 1; default: return 0; endcase
    endfunction
    function automatic logic [23:0] cfg_lit_left(input int i);
        case (i) 0: return 24'h00A5F0; 1: return 24'h008001; 2: return 24'h123457; default: return 24'h007FFF; endcase
    endfunction
    function automatic logic [23:0] cfg_lit_right(input int i);
        case (i) 0: return 24'h000F0F; 1: return 24'h00FFFF; 2: return 24'hABCDEF; default: return 24'h007FFF; endcase
    endfunction
    // Hand-written serial stream of the literal pair, stream index 0 at bit 63.
    function automatic logic [63:0] cfg_lit_stream(input int i);
        case (i)
            0:       return {16'hA5F0, 16'h0F0F, 32'h0};
            1:       return {16'h8001, 16'h0000, 16'hFFFF, 16'h0000};
            2:       return {24'h123457, 24'hABCDEF, 16'h0};
            default: return {16'h7FFF, 16'h0000, 16'h7FFF, 16'h0000};
        endcase
    endfunction

    // Stream bit at index idx of frame {lft, pad, rgt, pad}; index 0 is the left MSB.
    function automatic logic stream_bit(input logic [23:0] lft, input logic [23:0] rgt,
                                        input int idx, input int sample, input int slot);
        int k;
        k = idx % slot;
        if (k >= sample) return 1'b0;
        if (idx >= slot) return rgt[sample - 1 - k];
        return lft[sample - 1 - k];
    endfunction

    for (genvar g = 0; g < NCFG; g++) begin : g_cfg
        localparam int unsigned FMT  = cfg_fmt(g);
        localparam int unsigned SMP  = cfg_sample(g);
        localparam int unsigned SLT  = cfg_slot(g);
        localparam int unsigned DIV  = cfg_div(g);
        localparam int unsigned MUTE = cfg_mute(g);
        localparam int          FB   = int'(2 * SLT);

        logic           rst = 1'b1;
        logic           vld = 1'b0;
        logic [SMP-1:0] lft = '0;
        logic [SMP-1:0] rgt = '0;
        logic           rdy, bclk, lrclk, dac, fs, ur;
        logic           blk_done = 1'b0;

        // Model state: t = CLK edges since reset released, m_fr = index of the current frame.
        int          t = 0, m_p = FB - 1, m_fr = -1, acc_count = 0, c_fs = 0, c_ur = 0, nfall = 0;
        logic        m_full = 1'b0, m_ready = 1'b0, m_bclk = 1'b0, m_lrclk = 1'b0, m_dac = 1'b0;
        logic        m_fs = 1'b0, m_ur = 1'b0, m_fell = 1'b0, m_acc = 1'b0, pinned = 1'b0;
        logic [23:0] m_frm_l = '0, m_frm_r = '0, m_old_l = '0, m_old_r = '0, m_buf_l = '0, m_buf_r = '0;
        logic        cap1 [0:64];
        logic        cap3 [0:64];
        logic [63:0] v;

        i2s_tx_master #(
            .SAMPLE_WIDTH  (SMP),
            .SLOT_WIDTH    (SLT),
            .CLK_DIV       (DIV),
            .FORMAT        (FMT),
            .MUTE_ON_UNDER (MUTE)
        ) u_dut (
            .CLK         (clk),
            .RESET       (rst),
            .s_valid     (vld),
            .s_ready     (rdy),
            .s_left      (lft),
            .s_right     (rgt),
            .BCLK        (bclk),
            .LRCLK       (lrclk),
            .DACDAT      (dac),
            .frame_start (fs),
            .underrun    (ur)
        );

        // Model update on each edge, then compare every output 1 time unit later.
        initial forever begin : p_model
            @(posedge clk);
            m_fell = 1'b0;
            m_fs   = 1'b0;
            m_ur   = 1'b0;
            if (rst) begin
                t = 0; m_p = FB - 1; m_fr = -1;
                m_full = 1'b0; m_ready = 1'b0; m_bclk = 1'b0; m_lrclk = 1'b0; m_dac = 1'b0;
                m_frm_l = '0; m_frm_r = '0; m_old_l = '0; m_old_r = '0;
            end else begin
                m_acc  = vld && m_ready;
                t      = t + 1;
                m_bclk = ((t / int'(DIV)) % 2) == 1;
                if (t % (2 * int'(DIV)) == 0) begin
                    m_fell = 1'b1;
                    nfall  = t / (2 * int'(DIV));
                    m_p    = (nfall - 1) % FB;
                    if (m_p == 0) begin
                        m_fr    = m_fr + 1;
                        m_fs    = 1'b1;
                        m_old_l = m_frm_l;
                        m_old_r = m_frm_r;
                        if (m_full) begin
                            m_frm_l = m_buf_l;
                            m_frm_r = m_buf_r;
                            m_full  = 1'b0;
                        end else begin
                            m_ur = 1'b1;
                            if (MUTE != 0) begin
                                m_frm_l = '0;
                                m_frm_r = '0;
                            end
                        end
                    end
                    m_lrclk = (m_p >= int'(SLT));
                    if (FMT == FMT_LJ)
                        m_dac = stream_bit(m_frm_l, m_frm_r, m_p, int'(SMP), int'(SLT));
                    else if (m_p == 0)
                        m_dac = stream_bit(m_old_l, m_old_r, FB - 1, int'(SMP), int'(SLT));
                    else
                        m_dac = stream_bit(m_frm_l, m_frm_r, m_p - 1, int'(SMP), int'(SLT));
                end
                if (m_acc) begin
                    m_full    = 1'b1;
                    m_buf_l   = 24'(lft);
                    m_buf_r   = 24'(rgt);
                    acc_count = acc_count + 1;
                end
                m_ready = !m_full;
            end
            #1;
            check(g, "outputs", {58'd0, rdy, bclk, lrclk, dac, fs, ur},
                  {58'd0, m_ready, m_bclk, m_lrclk, m_dac, m_fs, m_ur});
            if (!pinned && !rst) begin
                c_fs += int'(fs);
                c_ur += int'(ur);
                if (m_fell) begin
                    if (m_fr == 1) cap1[m_p] = dac;
                    if (m_fr == 3) cap3[m_p] = dac;
                    if (m_fr == 2 && m_p == 0) begin
                        cap1[FB] = dac;
                        v = '0;
                        for (int i = 0; i < FB; i++) v[63 - i] = cap1[i + ((FMT == FMT_LJ) ? 0 : 1)];
                        check(g, "frame1_stream", v, cfg_lit_stream(g));
                    end
                    if (m_fr == 4 && m_p == 0) begin
                        cap3[FB] = dac;
                        v = '0;
                        for (int i = 0; i < FB; i++) v[63 - i] = cap3[i + ((FMT == FMT_LJ) ? 0 : 1)];
                        check(g, "frame3_underrun_stream", v, (MUTE != 0) ? 64'd0 : cfg_lit_stream(g));
                        check(g, "frame_start_count", 64'(c_fs), 64'd5);
                        check(g, "underrun_count", 64'(c_ur), 64'd4);
                        pinned = 1'b1;
                    end
                end
            end
        end

        // Stimulus: literal pair, underrun frames, random traffic, back-pressure, mid-frame reset.
        initial begin : p_stim
            int cnt;
            int last_acc;
            rst = 1'b1;
            repeat (3) @(negedge clk);
            check(g, "reset_state", {58'd0, rdy, bclk, lrclk, dac, fs, ur}, 64'd0);
            rst = 1'b0;
            @(negedge clk);
            check(g, "ready_after_reset", {63'd0, rdy}, 64'd1);
            for (int k = 0; k < LIMIT && m_fr < 0; k++) @(negedge clk);
            check(g, "first_load_underrun", {62'd0, fs, ur}, 64'd3);

            vld = 1'b1;
            lft = SMP'(cfg_lit_left(g));
            rgt = SMP'(cfg_lit_right(g));
            last_acc = acc_count;
            for (int k = 0; k < LIMIT && acc_count == last_acc; k++) @(negedge clk);
            if (acc_count == last_acc) check(g, "accept_timeout", 64'(acc_count), 64'(last_acc + 1));
            vld = 1'b0;
            lft = SMP'($urandom);
            rgt = SMP'($urandom);
            for (int k = 0; k < LIMIT && m_fr < 5; k++) @(negedge clk);
            if (m_fr < 5) check(g, "wait_frame5_timeout", 64'(m_fr), 64'd5);

            for (int k = 0; k < LIMIT && m_fr < 8; k++) begin
                vld = ($urandom_range(0, 31) == 0);
                lft = SMP'($urandom);
                rgt = SMP'($urandom);
                @(negedge clk);
            end

            cnt = 1;
            last_acc = acc_count;
            vld = 1'b1;
            for (int k = 0; k < LIMIT && m_fr < 12; k++) begin
                if (acc_count != last_acc) begin
                    cnt = cnt + 1;
                    last_acc = acc_count;
                end
                lft = SMP'(cnt);
                rgt = SMP'(~cnt);
                @(negedge clk);
            end
            if (m_fr < 12) check(g, "backpressure_timeout", 64'(m_fr), 64'd12);
            vld = 1'b0;

            for (int k = 0; k < LIMIT && !(m_lrclk && m_p == int'(SLT + SLT / 2)); k++) @(negedge clk);
            rst = 1'b1;
            @(negedge clk);
            check(g, "mid_reset_state", {58'd0, rdy, bclk, lrclk, dac, fs, ur}, 64'd0);
            @(negedge clk);
            rst = 1'b0;
            for (int k = 0; k < LIMIT && m_fr < 0; k++) @(negedge clk);
            check(g, "post_reset_underrun", {62'd0, fs, ur}, 64'd3);

            for (int k = 0; k < LIMIT && m_fr < 3; k++) begin
                vld = ($urandom_range(0, 15) == 0);
                lft = SMP'($urandom);
                rgt = SMP'($urandom);
                @(negedge clk);
            end
            vld = 1'b0;
            blk_done = 1'b1;
        end
    end

    // Wait for every configuration, then report.
    initial begin
        for (int k = 0; k < 60000; k++) begin
            @(negedge clk);
            if (g_cfg[0].blk_done && g_cfg[1].blk_done && g_cfg[2].blk_done && g_cfg[3].blk_done) break;
        end
        if (!(g_cfg[0].blk_done && g_cfg[1].blk_done && g_cfg[2].blk_done && g_cfg[3].blk_done)) begin
            n_checks++;
            n_fails++;
            $display("FAIL global_timeout: not all configurations finished");
        end
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end

endmodule
